vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 The block SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 The block SHALL have parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 The block SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 The block SHALL have parameters V_ACTIVE, V_FP, V_SYNC and V_BP, defaults 480, 10, 2 and 33, with the vertical meanings of REQ-001 to REQ-004, in lines.
REQ-006 The block SHALL have parameter HS_POL, default 0, active level of vga_h_sync.
REQ-007 The block SHALL have parameter VS_POL, default 0, active level of vga_v_sync.
REQ-008 The block SHALL have parameter CW, default 10, width of the Column and Row outputs.
REQ-009 The block SHALL have parameter FW, default 8, width of the frame counter.
REQ-010 Ports SHALL be:
  pxclk        in   1    pixel clock; all logic on the rising edge
  rst_n        in   1    reset: synchronous, active-low
  en           in   1    pixel advance enable
  vga_h_sync   out  1    horizontal sync
  vga_v_sync   out  1    vertical sync
  Column       out  CW   current horizontal position
  Row          out  CW   current vertical position
  Display      out  1    position lies in the visible area
  line_start   out  1    first pixel of a line
  frame_start  out  1    first pixel of a frame
  frame_cnt    out  FW   completed-frame count

Function
REQ-011 H_TOTAL SHALL be H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL SHALL be V_ACTIVE+V_FP+V_SYNC+V_BP.
REQ-012 Elaboration SHALL fail if H_TOTAL-1 or V_TOTAL-1 does not fit in CW bits, or if any timing parameter is 0.
REQ-013 The state machine SHALL have two states: IDLE and RUN.
REQ-014 In IDLE with en=1, the next edge SHALL load position (0,0) and enter RUN.
REQ-015 In IDLE with en=0, the block SHALL stay in IDLE.
REQ-016 In RUN with en=1, Column SHALL increment by 1 each edge; Column=H_TOTAL-1 SHALL wrap to 0 and advance Row.
REQ-017 Row SHALL increment on a Column wrap; Row=V_TOTAL-1 together with a Column wrap SHALL wrap Row to 0.
REQ-018 In RUN with en=0, every output SHALL hold its value; line_start and frame_start SHALL also hold, not clear.
REQ-019 All outputs SHALL be registered and SHALL describe the same (Column, Row) position in the same cycle, with zero skew between them.
REQ-020 Display SHALL be 1 exactly when Column<H_ACTIVE and Row<V_ACTIVE.
REQ-021 vga_h_sync SHALL equal HS_POL when H_ACTIVE+H_FP <= Column < H_ACTIVE+H_FP+H_SYNC, and !HS_POL otherwise.
REQ-022 vga_v_sync SHALL equal VS_POL when V_ACTIVE+V_FP <= Row < V_ACTIVE+V_FP+V_SYNC, and !VS_POL otherwise; it is independent of Column.
REQ-023 line_start SHALL be 1 exactly when in RUN with Column=0.
REQ-024 frame_start SHALL be 1 exactly when in RUN with Column=0 and Row=0.
REQ-025 frame_cnt SHALL increment, modulo 2^FW, on the edge where position wraps from (H_TOTAL-1, V_TOTAL-1) to (0,0).
REQ-026 frame_cnt SHALL NOT increment on the IDLE-to-RUN entry.

Reset
REQ-027 rst_n=0 sampled at a pxclk edge SHALL put the block in IDLE, with rst_n taking priority over en.
REQ-028 In IDLE, outputs SHALL be: Column=0, Row=0, Display=0, vga_h_sync=!HS_POL, vga_v_sync=!VS_POL, line_start=0, frame_start=0, frame_cnt=0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame; after release, the first en=1 edge SHALL present (0,0) with frame_start=1.

Verification
REQ-030 Default parameters, reset then en=1 continuously -> at the first RUN cycle: Column=0, Row=0, Display=1, line_start=1, frame_start=1, frame_cnt=0; Column=639 has Display=1 and Column=640 has Display=0.
REQ-031 Default parameters -> vga_h_sync=0 for Column 656..751 only (96 cycles per line); vga_v_sync=0 for Row 490..491 only (1600 cycles); frame period is 420000 enabled cycles.
REQ-032 H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1, HS_POL=1, FW=2 -> line period 8, frame period 48; vga_h_sync=1 at Column 5..6; vga_v_sync=0 at Row 4; frame_cnt sequence 0,1,2,3,0 at successive frame_start cycles.
REQ-033 en toggled as a 1-0-0-1 pattern -> outputs frozen on en=0 cycles, including held line_start=1; no position is skipped or repeated across enabled cycles.
REQ-034 rst_n=0 for 1 cycle at Column=300, Row=200 with frame_cnt=5 -> next cycle shows IDLE values per REQ-028; the first en=1 edge after release shows (0,0) with frame_start=1 and frame_cnt=0.
REQ-035 rst_n=0 and en=1 on the same edge -> the block SHALL be in IDLE, not RUN.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Purpose : VGA raster timing generator with (Column, Row) position, sync, blanking, line/frame markers and a frame counter.
// Latency : every output is registered and describes the same position in the same cycle; IDLE->RUN takes one enabled edge.
// Backpressure: en=0 freezes the raster and every output, including line_start/frame_start; nothing is dropped or skipped.
//
// Ports:
//   pxclk       pixel clock, all logic on the rising edge
//   rst_n       synchronous active-low reset, takes priority over en
//   en          pixel advance enable
//   vga_h_sync  horizontal sync, active level HS_POL
//   vga_v_sync  vertical sync, active level VS_POL (depends on Row only)
//   Column/Row  current raster position, CW bits each
//   Display     position lies inside the visible H_ACTIVE x V_ACTIVE area
//   line_start  first pixel of a line (Column == 0 while running)
//   frame_start first pixel of a frame (Column == 0, Row == 0 while running)
//   frame_cnt   completed-frame count, wraps modulo 2^FW

module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 10,
    parameter int FW       = 8
) (
    input  logic          pxclk,
    input  logic          rst_n,
    input  logic          en,
    output logic          vga_h_sync,
    output logic          vga_v_sync,
    output logic [CW-1:0] Column,
    output logic [CW-1:0] Row,
    output logic          Display,
    output logic          line_start,
    output logic          frame_start,
    output logic [FW-1:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
        $error("vga_timing_gen: every timing parameter must be at least 1");
    end

    if (CW < 1 || CW > 30 || FW < 1) begin : g_bad_width
        $error("vga_timing_gen: CW must be 1..30 and FW at least 1");
    end

    if (((H_TOTAL - 1) >> CW) != 0 || ((V_TOTAL - 1) >> CW) != 0) begin : g_bad_cw
        $error("vga_timing_gen: H_TOTAL-1 or V_TOTAL-1 does not fit in CW bits");
    end

    // Every boundary is strictly below the total, so once the CW check
    // holds all of these constants are exact in CW bits.
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t r_state;

    // ------------------------------------------------------------------
    // Position decode helpers, applied to the position being loaded so
    // that every flag lands in the same cycle as Column/Row.
    // ------------------------------------------------------------------
    function automatic logic f_hsync(input logic [CW-1:0] c);
        return ((c >= HS_START) && (c < HS_END)) ? HS_POL : ~HS_POL;
    endfunction

    function automatic logic f_vsync(input logic [CW-1:0] r);
        return ((r >= VS_START) && (r < VS_END)) ? VS_POL : ~VS_POL;
    endfunction

    function automatic logic f_display(input logic [CW-1:0] c, input logic [CW-1:0] r);
        return (c < H_VIS) && (r < V_VIS);
    endfunction

    // ------------------------------------------------------------------
    // Next raster position
    // ------------------------------------------------------------------
    logic          w_col_last;
    logic          w_row_last;
    logic          w_frame_wrap;
    logic [CW-1:0] w_col_inc;
    logic [CW-1:0] w_row_inc;
    logic [CW-1:0] w_col_tgt;
    logic [CW-1:0] w_row_tgt;

    assign w_col_last   = (Column == H_LAST);
    assign w_row_last   = (Row == V_LAST);
    assign w_frame_wrap = w_col_last && w_row_last;

    assign w_col_inc = w_col_last ? '0 : Column + CW'(1);
    assign w_row_inc = w_col_last ? (w_row_last ? '0 : Row + CW'(1)) : Row;

    // Leaving IDLE always starts a fresh frame at the origin, whatever
    // position a prior run may have reached before a reset.
    assign w_col_tgt = (r_state == S_RUN) ? w_col_inc : '0;
    assign w_row_tgt = (r_state == S_RUN) ? w_row_inc : '0;

    // ------------------------------------------------------------------
    // State machine and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge pxclk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            Column      <= '0;
            Row         <= '0;
            Display     <= 1'b0;
            vga_h_sync  <= ~HS_POL;
            vga_v_sync  <= ~VS_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else if (en) begin
            // With en low nothing is written, so every output (including
            // the line/frame markers) simply holds.
            r_state     <= S_RUN;
            Column      <= w_col_tgt;
            Row         <= w_row_tgt;
            Display     <= f_display(w_col_tgt, w_row_tgt);
            vga_h_sync  <= f_hsync(w_col_tgt);
            vga_v_sync  <= f_vsync(w_row_tgt);
            line_start  <= (w_col_tgt == '0);
            frame_start <= (w_col_tgt == '0) && (w_row_tgt == '0);
            // Only a genuine raster wrap completes a frame; the entry
            // from IDLE does not count.
            if ((r_state == S_RUN) && w_frame_wrap) begin
                frame_cnt <= frame_cnt + FW'(1);
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

    // Small raster used for most of the checks
    localparam int HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;   // 8
    localparam int VT = VA + VF + VS + VB;   // 6
    localparam bit HS_P = 1'b1;
    localparam bit VS_P = 1'b0;

    logic pxclk = 1'b0;
    always #5 pxclk = ~pxclk;

    // ---------------- small-raster DUT ----------------
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       s_hs, s_vs, s_disp, s_ls, s_fs;
    logic [3:0] s_col, s_row;
    logic [1:0] s_fc;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(HS_P), .VS_POL(VS_P), .CW(4), .FW(2)
    ) u_small (
        .pxclk(pxclk), .rst_n(rst_n), .en(en),
        .vga_h_sync(s_hs), .vga_v_sync(s_vs),
        .Column(s_col), .Row(s_row), .Display(s_disp),
        .line_start(s_ls), .frame_start(s_fs), .frame_cnt(s_fc)
    );

    // ---------------- default-parameter DUT ----------------
    logic       d_rst_n = 1'b0;
    logic       d_en = 1'b0;
    logic       d_hs, d_vs, d_disp, d_ls, d_fs;
    logic [9:0] d_col, d_row;
    logic [7:0] d_fc;

    vga_timing_gen u_dflt (
        .pxclk(pxclk), .rst_n(d_rst_n), .en(d_en),
        .vga_h_sync(d_hs), .vga_v_sync(d_vs),
        .Column(d_col), .Row(d_row), .Display(d_disp),
        .line_start(d_ls), .frame_start(d_fs), .frame_cnt(d_fc)
    );

    typedef struct packed {
        logic [3:0] col;
        logic [3:0] row;
        logic       disp;
        logic       hs;
        logic       vs;
        logic       ls;
        logic       fs;
        logic [1:0] fc;
    } obs_t;

    typedef struct {
        logic rst_n;
        logic en;
        obs_t exp;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: running flag plus number of enabled edges since RUN entry.
    bit m_run = 1'b0;
    int m_n   = 0;

    function automatic obs_t mk(input int c, input int r, input bit di, input bit h,
                                input bit v, input bit l, input bit f, input int fc);
        obs_t o;
        o.col = 4'(c); o.row = 4'(r); o.disp = di; o.hs = h; o.vs = v;
        o.ls = l; o.fs = f; o.fc = 2'(fc);
        return o;
    endfunction

    function automatic obs_t model(input bit run, input int n);
        int c, r, f;
        if (!run) return mk(0, 0, 0, ~HS_P, ~VS_P, 0, 0, 0);
        c = n % HT;
        r = (n / HT) % VT;
        f = (n / (HT * VT)) % 4;
        return mk(c, r, (c < HA) && (r < VA),
                  (c >= HA + HF && c < HA + HF + HS) ? HS_P : ~HS_P,
                  (r >= VA + VF && r < VA + VF + VS) ? VS_P : ~VS_P,
                  c == 0, c == 0 && r == 0, f);
    endfunction

    task automatic step(input logic r, input logic e);
        @(negedge pxclk);
        rst_n = r;
        en    = e;
        @(posedge pxclk);
        if (!r) begin
            m_run = 1'b0;
            m_n   = 0;
        end else if (e) begin
            if (!m_run) begin
                m_run = 1'b1;
                m_n   = 0;
            end else begin
                m_n++;
            end
        end
        #1;
    endtask

    task automatic chk(input string name, input obs_t exp);
        obs_t got;
        got = {s_col, s_row, s_disp, s_hs, s_vs, s_ls, s_fs, s_fc};
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got col=%0d row=%0d disp=%b hs=%b vs=%b ls=%b fs=%b fc=%0d, want col=%0d row=%0d disp=%b hs=%b vs=%b ls=%b fs=%b fc=%0d",
                     name, got.col, got.row, got.disp, got.hs, got.vs, got.ls, got.fs, got.fc,
                     exp.col, exp.row, exp.disp, exp.hs, exp.vs, exp.ls, exp.fs, exp.fc);
        end
    endtask

    task automatic cmp_int(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    vec_t tbl[14];
    int   fcs[$];
    int   exp_fc[4] = '{1, 2, 3, 0};
    int   vs_low, ls_cnt, hs_low;

    initial begin
        // {rst_n, en, expected outputs after the edge}
        tbl[0]  = '{1'b0, 1'b1, mk(0, 0, 0, 0, 1, 0, 0, 0)};  // reset wins over en
        tbl[1]  = '{1'b1, 1'b0, mk(0, 0, 0, 0, 1, 0, 0, 0)};  // idle stays idle
        tbl[2]  = '{1'b1, 1'b1, mk(0, 0, 1, 0, 1, 1, 1, 0)};  // RUN entry at origin
        tbl[3]  = '{1'b1, 1'b0, mk(0, 0, 1, 0, 1, 1, 1, 0)};  // held markers
        tbl[4]  = '{1'b1, 1'b0, mk(0, 0, 1, 0, 1, 1, 1, 0)};
        tbl[5]  = '{1'b1, 1'b1, mk(1, 0, 1, 0, 1, 0, 0, 0)};
        tbl[6]  = '{1'b1, 1'b1, mk(2, 0, 1, 0, 1, 0, 0, 0)};
        tbl[7]  = '{1'b1, 1'b1, mk(3, 0, 1, 0, 1, 0, 0, 0)};  // last visible column
        tbl[8]  = '{1'b1, 1'b1, mk(4, 0, 0, 0, 1, 0, 0, 0)};  // first blank column
        tbl[9]  = '{1'b1, 1'b1, mk(5, 0, 0, 1, 1, 0, 0, 0)};  // hsync active
        tbl[10] = '{1'b1, 1'b1, mk(6, 0, 0, 1, 1, 0, 0, 0)};
        tbl[11] = '{1'b1, 1'b1, mk(7, 0, 0, 0, 1, 0, 0, 0)};
        tbl[12] = '{1'b1, 1'b1, mk(0, 1, 1, 0, 1, 1, 0, 0)};  // column wrap
        tbl[13] = '{1'b1, 1'b0, mk(0, 1, 1, 0, 1, 1, 0, 0)};  // held line_start

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].rst_n, tbl[i].en);
            chk($sformatf("tbl[%0d]", i), tbl[i].exp);
        end

        // Run four full frame boundaries, collecting frame_cnt at frame_start.
        vs_low = 0;
        ls_cnt = 0;
        for (int i = 0; i < 300 && fcs.size() < 4; i++) begin
            step(1'b1, 1'b1);
            chk("frames", model(m_run, m_n));
            if (s_vs == 1'b0) vs_low++;
            if (s_ls) ls_cnt++;
            if (s_fs) fcs.push_back(int'(s_fc));
        end
        cmp_int("frame_start count", fcs.size(), 4);
        for (int i = 0; i < 4; i++) begin
            cmp_int($sformatf("frame_cnt seq[%0d]", i), (i < fcs.size()) ? fcs[i] : -1, exp_fc[i]);
        end
        cmp_int("vsync low cycles", vs_low, 4 * HT);
        cmp_int("line_start count", ls_cnt, 23);

        // Advance into frame 5 (frame_cnt=1, mid-frame), then reset with en=1.
        for (int i = 0; i < 60; i++) step(1'b1, 1'b1);
        chk("pre-reset", mk(4, 1, 0, 0, 1, 0, 0, 1));
        step(1'b0, 1'b1);
        chk("mid reset", mk(0, 0, 0, 0, 1, 0, 0, 0));
        step(1'b1, 1'b0);
        chk("post reset idle", mk(0, 0, 0, 0, 1, 0, 0, 0));
        step(1'b1, 1'b1);
        chk("restart origin", mk(0, 0, 1, 0, 1, 1, 1, 0));

        // Randomized enable / occasional reset against the reference model.
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 2) != 0));
            chk("random", model(m_run, m_n));
        end

        // Default parameters: first line of the 640x480 raster.
        @(negedge pxclk);
        d_rst_n = 1'b1;
        d_en    = 1'b1;
        @(posedge pxclk);
        #1;
        n_vec++;
        if ({d_col, d_row, d_disp, d_hs, d_vs, d_ls, d_fs, d_fc} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0}) begin
            n_bad++;
            $display("FAIL dflt entry: got col=%0d row=%0d disp=%b hs=%b vs=%b ls=%b fs=%b fc=%0d, want 0 0 1 1 1 1 1 0",
                     d_col, d_row, d_disp, d_hs, d_vs, d_ls, d_fs, d_fc);
        end
        hs_low = 0;
        for (int k = 1; k < 800; k++) begin
            @(posedge pxclk);
            #1;
            if (d_hs == 1'b0) hs_low++;
            n_vec++;
            if ({d_col, d_row, d_disp, d_hs, d_ls, d_fs} !==
                {10'(k), 10'd0, (k < 640), !(k >= 656 && k < 752), 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL dflt col %0d: got col=%0d row=%0d disp=%b hs=%b ls=%b fs=%b",
                         k, d_col, d_row, d_disp, d_hs, d_ls, d_fs);
            end
        end
        cmp_int("dflt hsync low cycles", hs_low, 96);
        @(posedge pxclk);
        #1;
        n_vec++;
        if ({d_col, d_row, d_ls, d_fs, d_disp} !== {10'd0, 10'd1, 1'b1, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL dflt line wrap: got col=%0d row=%0d ls=%b fs=%b disp=%b, want 0 1 1 0 1",
                     d_col, d_row, d_ls, d_fs, d_disp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
